// File: rtl/a5_wb_regs.sv
// rtl/a5_wb_regs.sv - Wishbone register block for the A5 keystream engine.
// Holds key/frame, issues load pulses and pops keystream words on DATA reads.
module a5_wb_regs #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  load,
  output logic [63:0]           key,
  output logic [21:0]           frame,
  output logic                  rd_en,
  input  logic [31:0]           data_in,
  input  logic                  empty
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_KEY_LO = 3'd2;
  localparam logic [2:0] REG_KEY_HI = 3'd3;
  localparam logic [2:0] REG_FRAME  = 3'd4;
  localparam logic [2:0] REG_DATA   = 3'd5;

  logic        autoinc;
  logic        underflow;
  logic        accept;
  logic        wr;
  logic        rd;
  logic [2:0]  idx;
  logic        start_req;
  logic        pop_req;
  logic        uf_set;
  logic        uf_clr;
  logic [31:0] rd_mux;
  logic [31:0] key_lo_wr;
  logic [31:0] key_hi_wr;
  logic [21:0] frame_wr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // The ack register doubles as the busy flag: nothing is accepted while it is high.
  assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr     = accept & wb_we_i;
  assign rd     = accept & ~wb_we_i;
  assign idx    = wb_adr_i[4:2];

  assign start_req = wr & (idx == REG_CTRL) & wb_sel_i[0] & wb_dat_i[0];
  assign pop_req   = rd & (idx == REG_DATA) & ~empty;
  assign uf_set    = rd & (idx == REG_DATA) & empty;
  assign uf_clr    = (rd & (idx == REG_STATUS)) | load;

  assign key_lo_wr = lane_merge(key[31:0], wb_dat_i, wb_sel_i);
  assign key_hi_wr = lane_merge(key[63:32], wb_dat_i, wb_sel_i);

  // Only bits [21:0] of FRAME exist; lane 3 and the top of lane 2 are dropped.
  always_comb begin
    frame_wr = frame;
    if (wb_sel_i[0]) frame_wr[7:0]   = wb_dat_i[7:0];
    if (wb_sel_i[1]) frame_wr[15:8]  = wb_dat_i[15:8];
    if (wb_sel_i[2]) frame_wr[21:16] = wb_dat_i[21:16];
  end

  always_comb begin
    rd_mux = 32'd0;
    case (idx)
      REG_CTRL:   rd_mux = {30'd0, autoinc, 1'b0};
      REG_STATUS: rd_mux = {30'd0, underflow, empty};
      REG_KEY_LO: rd_mux = key[31:0];
      REG_KEY_HI: rd_mux = key[63:32];
      REG_FRAME:  rd_mux = {10'd0, frame};
      REG_DATA:   rd_mux = empty ? 32'd0 : data_in;
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 32'd0;
      load      <= 1'b0;
      rd_en     <= 1'b0;
      key       <= 64'd0;
      frame     <= 22'd0;
      autoinc   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wb_ack_o <= accept;
      load     <= start_req;
      rd_en    <= pop_req & ~start_req;

      if (rd) wb_dat_o <= rd_mux;

      if (wr && idx == REG_CTRL && wb_sel_i[0]) autoinc <= wb_dat_i[1];
      if (wr && idx == REG_KEY_LO) key[31:0]  <= key_lo_wr;
      if (wr && idx == REG_KEY_HI) key[63:32] <= key_hi_wr;

      // A FRAME write cannot coincide with a load cycle since ack blocks acceptance.
      if (wr && idx == REG_FRAME) frame <= frame_wr;
      else if (load && autoinc)   frame <= frame + 22'd1;

      if (uf_set)      underflow <= 1'b1;
      else if (uf_clr) underflow <= 1'b0;
    end
  end

endmodule
